// File: rtl/led_pwm_pkg.sv
// Shared widths, fade event bundle and helpers for the LED PWM fader.
// Gamma helper is only referenced when LED_PWM_GAMMA_EN is defined.
package led_pwm_pkg;

    localparam int NCH_DEF    = 3;
    localparam int PWM_W_DEF  = 8;
    localparam int PRE_W_DEF  = 8;
    localparam int RATE_W_DEF = 8;

    // Per-boundary broadcast from the shared timebase to every channel.
    typedef struct packed {
        logic jump;   // boundary with fade_rate == 0: current snaps to target
        logic step;   // boundary that completes a fade interval: move 1 LSB
    } fade_evt_t;

    // Ceiling log2, never less than 1 so a single channel still has an address bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w = w + 1;
        return w;
    endfunction

    // Square-law brightness curve; full scale is kept at full scale.
    function automatic logic [31:0] gamma(input logic [31:0] c, input int w);
        logic [63:0] sq;
        logic [31:0] full;
        full = (32'd1 << w) - 32'd1;
        if (c == full) return c;
        sq = 64'(c) * 64'(c);
        return 32'(sq >> w);
    endfunction

endpackage

// File: rtl/led_pwm_chan.sv
// One PWM channel: target/current duty, linear fade stepping, compare stage, busy flag.
// Latency: 1 clk counter-to-pin; duty changes only at period boundaries; no backpressure. LED_PWM_GAMMA_EN selects gamma compare.
module led_pwm_chan
    import led_pwm_pkg::*;
#(
    parameter int PWM_W = PWM_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [PWM_W-1:0] wr_data,
    input  logic [PWM_W-1:0] pwm_cnt,
    input  fade_evt_t        evt,
    output logic             pwm_out,
    output logic             busy
);

    logic [PWM_W-1:0] target;
    logic [PWM_W-1:0] current;
    logic [PWM_W-1:0] duty;

`ifdef LED_PWM_GAMMA_EN
    always_comb duty = PWM_W'(gamma(32'(current), PWM_W));
`else
    always_comb duty = current;
`endif

    assign busy = (current != target);

    // Boundary logic sees the pre-write target: the write lands in the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            target  <= '0;
            current <= '0;
            pwm_out <= 1'b0;
        end else begin
            if (evt.jump) begin
                current <= target;
            end else if (evt.step) begin
                if (current < target)
                    current <= current + PWM_W'(1);
                else if (current > target)
                    current <= current - PWM_W'(1);
            end
            if (wr_en)
                target <= wr_data;
            pwm_out <= (pwm_cnt < duty);
        end
    end

endmodule

// File: rtl/led_pwm_fader.sv
// Multi-channel PWM LED fader: shared prescaler, PWM counter and fade divider feeding NCH channels.
// Latency: 1 clk counter-to-pin, period_strb 1 clk after boundary; no backpressure. Optional: LED_PWM_GAMMA_EN.
module led_pwm_fader
    import led_pwm_pkg::*;
#(
    parameter  int NCH    = NCH_DEF,
    parameter  int PWM_W  = PWM_W_DEF,
    parameter  int PRE_W  = PRE_W_DEF,
    parameter  int RATE_W = RATE_W_DEF,
    localparam int AW     = clog2_min1(NCH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PRE_W-1:0]  prescale,
    input  logic [RATE_W-1:0] fade_rate,
    input  logic              wr,
    input  logic [AW-1:0]     wr_addr,
    input  logic [PWM_W-1:0]  wr_data,
    output logic [NCH-1:0]    pwm_out,
    output logic [NCH-1:0]    busy,
    output logic              period_strb
);

    logic [PRE_W-1:0]  pre_cnt;
    logic [PWM_W-1:0]  pwm_cnt;
    logic [RATE_W-1:0] fade_cnt;
    logic              tick;
    logic              boundary;
    fade_evt_t         evt;

    assign tick     = (pre_cnt == prescale);
    assign boundary = tick && (pwm_cnt == '1);

    always_comb begin
        evt      = '0;
        evt.jump = boundary && (fade_rate == '0);
        evt.step = boundary && (fade_rate != '0) && (fade_cnt == fade_rate - RATE_W'(1));
    end

    // A prescale lowered below the running count lets pre_cnt wrap through zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt     <= '0;
            pwm_cnt     <= '0;
            fade_cnt    <= '0;
            period_strb <= 1'b0;
        end else begin
            pre_cnt     <= tick ? '0 : pre_cnt + PRE_W'(1);
            period_strb <= boundary;
            if (tick)
                pwm_cnt <= pwm_cnt + PWM_W'(1);
            if (boundary && (fade_rate != '0))
                fade_cnt <= evt.step ? '0 : fade_cnt + RATE_W'(1);
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        led_pwm_chan #(
            .PWM_W (PWM_W)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (wr && (wr_addr == AW'(i))),
            .wr_data (wr_data),
            .pwm_cnt (pwm_cnt),
            .evt     (evt),
            .pwm_out (pwm_out[i]),
            .busy    (busy[i])
        );
    end

endmodule
